uart_echo_responder: RTL
========================

// Module: uart_echo_responder
// PURPOSE
//  Hardware far-end for the UART loopback traffic. Sits between the uart core's receive
//  side (rdy/dout/rdy_clr) and its transmit side (din/wr_en/tx_busy).
//  Every received byte is optionally XOR-transformed and retransmitted in arrival order.
//  A FIFO buffers bytes while the transmitter is busy. Lets a board answer a host exerciser with no CPU.
// PARAMETERS
//  FIFO_AW       4      FIFO address width; depth = 2**FIFO_AW entries
//  XOR_MASK      8'h00  XORed onto each byte on its way out (8'h00 = plain echo)
//  BUSY_TIMEOUT  15     cycles to wait for tx_busy to rise after a write (range 1..255)
// PORTS
//  clk_50m      in   1          system clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  rx_rdy       in   1          uart rdy: received byte valid, held until cleared
//  rx_data      in   8          uart dout
//  rx_rdy_clr   out  1          uart rdy_clr: one-cycle pulse acknowledging rx byte
//  tx_din       out  8          uart din
//  tx_wr_en     out  1          uart wr_en: one-cycle pulse starting a transmit
//  tx_busy      in   1          uart tx_busy
//  echo_en      in   1          1 = drain FIFO to tx; 0 = hold bytes (rx still accepted)
//  ovf_clr      in   1          clears sticky overflow
//  overflow     out  1          sticky: a byte was dropped because FIFO was full
//  fifo_count   out  FIFO_AW+1  bytes currently buffered
//  byte_count   out  16         bytes transmitted since reset, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 (rx_rdy_clr, tx_din, tx_wr_en, overflow, fifo_count, byte_count).
//   FIFO emptied, both FSMs -> IDLE. Applies mid-transfer; bytes buffered before reset are lost.
//  RX FSM: R_IDLE, R_ACK, R_WAIT.
//   R_IDLE & rx_rdy: if FIFO not full, push rx_data; else drop it and set overflow. Go to R_ACK.
//   R_ACK: rx_rdy_clr=1 for exactly this cycle -> R_WAIT.
//   R_WAIT: stay until rx_rdy==0, then R_IDLE. Exactly one push or drop per byte.
//  TX FSM: T_IDLE, T_LOAD, T_WAIT_HI, T_WAIT_LO.
//   T_IDLE & echo_en & FIFO not empty & !tx_busy: pop; register tx_din = head ^ XOR_MASK -> T_LOAD.
//   T_LOAD: tx_wr_en=1 (one cycle, tx_din stable); byte_count++ -> T_WAIT_HI.
//   T_WAIT_HI: tx_busy==1 -> T_WAIT_LO. After BUSY_TIMEOUT cycles with no rise -> T_IDLE
//    (byte treated as sent, no error flag).
//   T_WAIT_LO: tx_busy==0 -> T_IDLE.
//   Minimum spacing between tx_wr_en pulses: 3 cycles.
//   echo_en falling mid-byte does not abort that byte; it only blocks the next pop.
//  FIFO: first-in first-out, pointers wrap modulo depth, fifo_count = wr - rd.
//   Same-cycle push and pop: both occur, count unchanged.
//   Full check uses the count at the start of the cycle; a same-cycle pop does not make room.
//   Pop never occurs when empty; push never occurs when full.
//  overflow: set on drop; ovf_clr clears it. A drop in the same cycle as ovf_clr wins (stays 1).
//  tx_din holds the last transmitted byte between transfers.
// TESTING
//  1 rx 8'h5A, tx_busy 1 for 20 cycles after wr_en -> one rx_rdy_clr pulse, one tx_wr_en with
//    tx_din=8'h5A, byte_count=1, fifo_count back to 0.
//  2 echo_en=0, send 8'h01..8'h10 (16 bytes) -> fifo_count=16, overflow=0; a 17th byte 8'h11 ->
//    overflow=1, fifo_count=16; set echo_en=1 -> 16 wr_en pulses carrying 01..10 in order; 8'h11 never sent.
//  3 XOR_MASK=8'h20, rx 8'h61 -> tx_din=8'h41; ovf_clr pulse after test 2 -> overflow=0.
//  4 push arrives in the same cycle as a pop with fifo_count=3 -> fifo_count stays 3, order preserved.
//  5 tx_busy tied 0, rx 8'hA5 -> wr_en pulse, T_IDLE after exactly BUSY_TIMEOUT cycles, byte_count=1.
//  6 rst asserted during T_WAIT_LO with 5 bytes queued -> next cycle all outputs 0, fifo_count 0;
//    a subsequent rx 8'hC3 echoes normally.

Source files
------------

// File: rtl/uart_echo_responder.sv
// UART echo responder: takes bytes from the uart receive handshake, buffers them in a small
// FIFO and retransmits each one (optionally XOR-transformed) through the uart transmit side.
// Two independent FSMs: the RX side pushes into the FIFO, the TX side pops and transmits.

module uart_echo_responder #(
  parameter int unsigned FIFO_AW      = 4,
  parameter logic [7:0]  XOR_MASK     = 8'h00,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             rx_rdy_clr,
  output logic [7:0]       tx_din,
  output logic             tx_wr_en,
  input  logic             tx_busy,
  input  logic             echo_en,
  input  logic             ovf_clr,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count,
  output logic [15:0]      byte_count
);

  localparam int unsigned Depth       = 2 ** FIFO_AW;
  localparam logic [7:0]  TimeoutLast = 8'(BUSY_TIMEOUT - 1);
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RxIdle,
    RxAck,
    RxWait
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxLoad,
    TxWaitHi,
    TxWaitLo
  } tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]       mem_q [Depth];

  logic       fifo_full, fifo_empty;
  logic       push, drop, pop;
  logic [7:0] timer_q, timer_d;
  logic [7:0] tx_din_q;
  logic       overflow_q;
  logic [15:0] byte_count_q;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Full is judged on start-of-cycle pointers, so a same-cycle pop never frees a slot.
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  assign tx_din     = tx_din_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

  // RX next-state: accept (push or drop) once per byte, acknowledge, then wait for rdy to drop.
  always_comb begin
    rx_state_d = rx_state_q;
    push       = 1'b0;
    drop       = 1'b0;
    rx_rdy_clr = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_rdy) begin
          if (fifo_full) begin
            drop = 1'b1;
          end else begin
            push = 1'b1;
          end
          rx_state_d = RxAck;
        end
      end
      RxAck: begin
        rx_rdy_clr = 1'b1;
        rx_state_d = RxWait;
      end
      RxWait: begin
        if (!rx_rdy) begin
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // TX next-state: pop, strobe wr_en, then follow tx_busy up and down (with a rise timeout).
  always_comb begin
    tx_state_d = tx_state_q;
    timer_d    = timer_q;
    pop        = 1'b0;
    tx_wr_en   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        timer_d = 8'd0;
        if (echo_en && !fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          tx_state_d = TxLoad;
        end
      end
      TxLoad: begin
        tx_wr_en   = 1'b1;
        timer_d    = 8'd0;
        tx_state_d = TxWaitHi;
      end
      TxWaitHi: begin
        if (tx_busy) begin
          tx_state_d = TxWaitLo;
        end else if (timer_q == TimeoutLast) begin
          // Transmitter never acknowledged; treat the byte as sent.
          tx_state_d = TxIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      TxWaitLo: begin
        if (!tx_busy) begin
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      tx_state_q <= TxIdle;
      timer_q    <= 8'd0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      timer_q    <= timer_d;
    end
  end

  // FIFO pointers; reset discards anything buffered.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // FIFO storage, no reset needed since contents are guarded by the pointers.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rx_data;
    end
  end

  // Transmit data register; holds the last transmitted byte between transfers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_din_q <= 8'h00;
    end else if (pop) begin
      tx_din_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]] ^ XOR_MASK;
    end
  end

  // Transmitted-byte counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      byte_count_q <= 16'h0000;
    end else if (tx_wr_en) begin
      byte_count_q <= byte_count_q + 16'd1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule
